// File: rtl/modulo_divider_if.sv
// Handshake bundle for modulo_divider: operand channel (valid_i/ready_i/a/b)
// and result channel (valid_o/ready_o/q/r/y/dz).
// The master side is the producer/consumer; the slave side is the divider.
interface modulo_divider_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_i;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             y;
  logic             dz;
  logic             valid_o;
  logic             ready_o;

  modport master (
    output valid_i, a, b, ready_o,
    input  ready_i, q, r, y, dz, valid_o
  );

  modport slave (
    input  valid_i, a, b, ready_o,
    output ready_i, q, r, y, dz, valid_o
  );
endinterface

// File: rtl/modulo_divider.sv
// modulo_divider: iterative restoring unsigned divider, one quotient bit per
// cycle, MSB first. Returns quotient, remainder, remainder-is-zero flag (y)
// and divide-by-zero flag (dz). One division in flight; the result is held
// in DONE until the consumer accepts it.
// Optional feature macro: MODULO_DIVIDER_EARLY_EXIT_EN -- when defined, a
// dividend smaller than a non-zero divisor finishes at accept (1-cycle
// latency). Result values are identical either way.
module modulo_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  modulo_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < b between steps
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             y_q, y_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;      // WIDTH+1 bit shifted partial remainder
  logic [WIDTH-1:0] rem_sub;
  logic             q_bit;
  logic             short_path;

  // One restoring step: shift in the next dividend bit and trial-subtract b.
  // When the subtraction is taken the difference is < b, so WIDTH bits hold it.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, b_q});
    rem_sub   = rem_shift[WIDTH-1:0] - b_q;
  end

`ifdef MODULO_DIVIDER_EARLY_EXIT_EN
  assign short_path = (bus.a < bus.b);
`else
  assign short_path = 1'b0;
`endif

  // Next-state and datapath decode for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    y_d     = y_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          dvd_d = bus.a;
          b_d   = bus.b;
          if (bus.b == '0) begin
            q_d     = '1;
            r_d     = bus.a;
            y_d     = 1'b0;
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (short_path) begin
            q_d     = '0;
            r_d     = bus.a;
            y_d     = (bus.a == '0);
            dz_d    = 1'b0;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        rem_d = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = dvd_d;
          r_d     = rem_d;
          y_d     = (rem_d == '0);
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.ready_o) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      y_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      y_q     <= y_d;
      dz_q    <= dz_d;
    end
  end

  // Handshake flags come straight from the state flops.
  assign bus.ready_i = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.q       = q_q;
  assign bus.r       = r_q;
  assign bus.y       = y_q;
  assign bus.dz      = dz_q;

endmodule

// File: tb/tb_modulo_divider.sv
// Directed testbench for modulo_divider at WIDTH=32.
// Latency is counted as clock edges after the accept edge until valid_o is
// first seen high: WIDTH for the iterative path, 0 for the one-cycle paths.
module tb_modulo_divider;

  localparam int          W    = 32;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
`ifdef MODULO_DIVIDER_EARLY_EXIT_EN
  localparam int SHORT_LAT = 0;
`else
  localparam int SHORT_LAT = 32;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  modulo_divider_if #(.WIDTH(W)) bus ();

  modulo_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold valid_i until an edge with ready_i high;
  // waited counts the edges where valid_i was high but not accepted.
  task automatic accept(input logic [31:0] av, input logic [31:0] bv, output int waited);
    logic rdy;
    waited      = 0;
    bus.a       = av;
    bus.b       = bv;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rdy = bus.ready_i;
      tick();
      if (rdy) break;
      waited++;
    end
    bus.valid_i = 1'b0;
    bus.a       = 32'hDEAD_BEEF;
    bus.b       = 32'h0000_0000;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!bus.valid_o && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                              input logic ey, input logic edz);
    check({tag, ".valid_o"}, 64'(bus.valid_o), 64'(1'b1));
    check({tag, ".q"},       64'(bus.q),       64'(eq));
    check({tag, ".r"},       64'(bus.r),       64'(er));
    check({tag, ".y"},       64'(bus.y),       64'(ey));
    check({tag, ".dz"},      64'(bus.dz),      64'(edz));
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eq, input logic [31:0] er, input logic ey,
                     input logic edz, input int elat, input int ewait);
    int waited;
    int lat;
    accept(av, bv, waited);
    check({tag, ".accept_wait"}, 64'(waited), 64'(ewait));
    wait_valid(lat);
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check_result(tag, eq, er, ey, edz);
    $display("txn %s a=%0d b=%0d -> q=%0h r=%0h y=%0b dz=%0b lat=%0d",
             tag, av, bv, bus.q, bus.r, bus.y, bus.dz, lat);
  endtask

  initial begin
    int waited;
    int lat;
    int vcount;
    logic [31:0] q_hold;
    logic [31:0] r_hold;

    bus.valid_i = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.ready_o = 1'b1;

    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset.ready_i", 64'(bus.ready_i), 64'(1'b1));
    check("reset.valid_o", 64'(bus.valid_o), 64'(1'b0));
    check("reset.q",       64'(bus.q),       64'(0));
    check("reset.r",       64'(bus.r),       64'(0));
    check("reset.y",       64'(bus.y),       64'(1'b0));
    check("reset.dz",      64'(bus.dz),      64'(1'b0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    run("div100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, 0);

    // Back-to-back: valid_i already high in DONE; accept lands one edge after handshake.
    run("div91_13", 32'd91, 32'd13, 32'd7, 32'd0, 1'b1, 1'b0, 32, 1);
    run("div97_13", 32'd97, 32'd13, 32'd7, 32'd6, 1'b0, 1'b0, 32, 1);

    run("div55_0", 32'd55, 32'd0, ONES, 32'd55, 1'b0, 1'b1, 0, 1);

    // Result held while the consumer stalls.
    accept(ONES, 32'd1, waited);
    check("hold.accept_wait", 64'(waited), 64'(1));
    bus.ready_o = 1'b0;
    wait_valid(lat);
    check("hold.latency", 64'(lat), 64'(32));
    check_result("hold", ONES, 32'd0, 1'b1, 1'b0);
    $display("txn hold a=%0h b=1 -> q=%0h r=%0h lat=%0d", ONES, bus.q, bus.r, lat);
    q_hold = bus.q;
    r_hold = bus.r;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.stall_valid_o", 64'(bus.valid_o), 64'(1'b1));
      check("hold.stall_ready_i", 64'(bus.ready_i), 64'(1'b0));
      check("hold.stall_q",       64'(bus.q),       64'(ONES));
      check("hold.stall_r",       64'(bus.r),       64'(0));
    end
    bus.ready_o = 1'b1;
    tick();
    check("hold.after_valid_o", 64'(bus.valid_o), 64'(1'b0));
    check("hold.after_ready_i", 64'(bus.ready_i), 64'(1'b1));
    check("hold.after_q_kept",  64'(bus.q),       64'(q_hold));
    check("hold.after_r_kept",  64'(bus.r),       64'(r_hold));

    // Reset in the middle of BUSY aborts the division.
    accept(32'd1000, 32'd3, waited);
    check("abort.accept_wait", 64'(waited), 64'(0));
    repeat (10) tick();
    #1 rst = 1'b1;
    #1;
    check("abort.ready_i", 64'(bus.ready_i), 64'(1'b1));
    check("abort.valid_o", 64'(bus.valid_o), 64'(1'b0));
    check("abort.q",       64'(bus.q),       64'(0));
    check("abort.r",       64'(bus.r),       64'(0));
    check("abort.y",       64'(bus.y),       64'(1'b0));
    check("abort.dz",      64'(bus.dz),      64'(1'b0));
    tick();
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_o) vcount++;
    end
    check("abort.no_valid_o", 64'(vcount), 64'(0));
    $display("txn abort a=1000 b=3 reset after 10 busy cycles");

    run("div9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 32, 0);
    run("div5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, SHORT_LAT, 1);
    run("div0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, SHORT_LAT, 1);
    run("div_eq", 32'd12345, 32'd12345, 32'd1, 32'd0, 1'b1, 1'b0, 32, 1);

    tick();
    check("final.ready_i", 64'(bus.ready_i), 64'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
